// File: rtl/r4_butterfly_stream.sv
// r4_butterfly_stream
// Pipelined radix-4 DIT butterfly with a valid/ready output stream.
// An accepted transaction has four complex W-bit samples a..d. The block
// computes X0..X3 at W+2 bit precision, with optional forward/inverse
// direction and optional 1/4 scaling. It buffers all four results and
// emits them one per cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   in_valid / in_ready    input handshake
//   inv, scale             direction and 1/4 scaling, sampled on accept
//   xr0..xr3, xi0..xi3     real/imag parts of a, b, c, d (signed W)
//   out_valid / out_ready  output handshake
//   out_re, out_im         result components (signed W+2)
//   out_idx, out_last      output index k of Xk, high on X3
//   done_cnt               number of fully drained butterflies (wraps)
//
// state  | meaning
// EMPTY  | buffer empty, ready for a new butterfly
// DRAIN  | buffer holds results, presenting buffer[idx]
module r4_butterfly_stream #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          inv,
  input  logic          scale,
  input  logic [W-1:0]  xr0,
  input  logic [W-1:0]  xr1,
  input  logic [W-1:0]  xr2,
  input  logic [W-1:0]  xr3,
  input  logic [W-1:0]  xi0,
  input  logic [W-1:0]  xi1,
  input  logic [W-1:0]  xi2,
  input  logic [W-1:0]  xi3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W+1:0]  out_re,
  output logic [W+1:0]  out_im,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic [CW-1:0] done_cnt
);

  localparam int OW = W + 2;

  typedef enum logic {S_EMPTY, S_DRAIN} state_t;

  state_t               state_q;
  logic [1:0]           idx_q;
  logic signed [OW-1:0] re_q [4];
  logic signed [OW-1:0] im_q [4];
  logic [CW-1:0]        cnt_q;

  logic signed [OW-1:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [OW-1:0] x1r, x1i, x3r, x3i;
  logic signed [OW-1:0] raw_re [4];
  logic signed [OW-1:0] raw_im [4];
  logic signed [OW-1:0] res_re_d [4];
  logic signed [OW-1:0] res_im_d [4];
  logic                 accept;

  // Extend the inputs by two sign bits. The sum of four W-bit values
  // then fits exactly, so the arithmetic below never overflows.
  assign ar = {{2{xr0[W-1]}}, xr0};
  assign br = {{2{xr1[W-1]}}, xr1};
  assign cr = {{2{xr2[W-1]}}, xr2};
  assign dr = {{2{xr3[W-1]}}, xr3};
  assign ai = {{2{xi0[W-1]}}, xi0};
  assign bi = {{2{xi1[W-1]}}, xi1};
  assign ci = {{2{xi2[W-1]}}, xi2};
  assign di = {{2{xi3[W-1]}}, xi3};

  assign x1r = ar - cr + bi - di;
  assign x1i = ai - ci - br + dr;
  assign x3r = ar - cr - bi + di;
  assign x3i = ai - ci + br - dr;

  always_comb begin
    raw_re[0] = ar + br + cr + dr;
    raw_im[0] = ai + bi + ci + di;
    raw_re[2] = ar - br + cr - dr;
    raw_im[2] = ai - bi + ci - di;
    // The inverse transform is the forward one with X1 and X3 swapped.
    raw_re[1] = inv ? x3r : x1r;
    raw_im[1] = inv ? x3i : x1i;
    raw_re[3] = inv ? x1r : x3r;
    raw_im[3] = inv ? x1i : x3i;
    for (int k = 0; k < 4; k++) begin
      res_re_d[k] = scale ? (raw_re[k] >>> 2) : raw_re[k];
      res_im_d[k] = scale ? (raw_im[k] >>> 2) : raw_im[k];
    end
  end

  // A new butterfly may enter in the same cycle that X3 leaves, so there
  // is no bubble between back-to-back transactions.
  assign in_ready = (state_q == S_EMPTY) |
                    ((state_q == S_DRAIN) & (idx_q == 2'd3) & out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_EMPTY;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        for (int k = 0; k < 4; k++) begin
          re_q[k] <= res_re_d[k];
          im_q[k] <= res_im_d[k];
        end
      end
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_q <= S_DRAIN;
            idx_q   <= 2'd0;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              idx_q   <= 2'd0;
              state_q <= accept ? S_DRAIN : S_EMPTY;
            end
          end
        end
        default: begin
          state_q <= S_EMPTY;
          idx_q   <= 2'd0;
        end
      endcase
    end
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_re    = re_q[idx_q];
  assign out_im    = im_q[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == 2'd3);
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_r4_butterfly_stream.sv
module tb_r4_butterfly_stream;
  localparam int W  = 4;
  localparam int CW = 8;

  logic                wb_clk_i, wb_rst_i;
  logic                in_valid, in_ready, inv, scale;
  logic signed [W-1:0] xr_s [4];
  logic signed [W-1:0] xi_s [4];
  logic                out_valid, out_ready, out_last;
  logic [W+1:0]        out_re, out_im;
  logic [1:0]          out_idx;
  logic [CW-1:0]       done_cnt;

  r4_butterfly_stream #(.W(W), .CW(CW)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .in_valid (in_valid), .in_ready (in_ready),
    .inv (inv), .scale (scale),
    .xr0 (xr_s[0]), .xr1 (xr_s[1]), .xr2 (xr_s[2]), .xr3 (xr_s[3]),
    .xi0 (xi_s[0]), .xi1 (xi_s[1]), .xi2 (xi_s[2]), .xi3 (xi_s[3]),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_re (out_re), .out_im (out_im),
    .out_idx (out_idx), .out_last (out_last),
    .done_cnt (done_cnt)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit rdy_rand = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Radix-4 DFT of (a,b,c,d) evaluated directly for output k.
  function automatic int bfly(input int a_r, input int a_i, input int b_r, input int b_i,
                              input int c_r, input int c_i, input int d_r, input int d_i,
                              input int k, input bit iv, input bit sc, input bit want_im);
    int re, im, kk;
    kk = (iv && (k % 2 == 1)) ? 4 - k : k;
    case (kk)
      0: begin re = a_r + b_r + c_r + d_r; im = a_i + b_i + c_i + d_i; end
      1: begin re = a_r - c_r + b_i - d_i; im = a_i - c_i - b_r + d_r; end
      2: begin re = a_r - b_r + c_r - d_r; im = a_i - b_i + c_i - d_i; end
      default: begin re = a_r - c_r - b_i + d_i; im = a_i - c_i + b_r - d_r; end
    endcase
    if (sc) begin
      re = re >>> 2;
      im = im >>> 2;
    end
    return want_im ? im : re;
  endfunction

  typedef struct {int re; int im; int idx;} exp_t;
  exp_t q[$];
  int   m_cnt = 0;

  // Reference model: a FIFO of expected samples plus a drained-butterfly count.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit exp_rdy, acc;
      exp_t e;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      acc = in_valid && exp_rdy;
      if (q.size() > 0 && out_ready) begin
        e = q.pop_front();
        if (e.idx == 3) m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          e.re  = bfly(int'(xr_s[0]), int'(xi_s[0]), int'(xr_s[1]), int'(xi_s[1]),
                       int'(xr_s[2]), int'(xi_s[2]), int'(xr_s[3]), int'(xi_s[3]), k, inv, scale, 1'b0);
          e.im  = bfly(int'(xr_s[0]), int'(xi_s[0]), int'(xr_s[1]), int'(xi_s[1]),
                       int'(xr_s[2]), int'(xi_s[2]), int'(xr_s[3]), int'(xi_s[3]), k, inv, scale, 1'b1);
          e.idx = k;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge wb_clk_i) begin
    #2;
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("in_ready", int'(in_ready), int'((q.size() == 0) || (q.size() == 1 && out_ready)));
    chk("done_cnt", int'(done_cnt), m_cnt);
    if (q.size() > 0) begin
      chk("out_re", int'($signed(out_re)), q[0].re);
      chk("out_im", int'($signed(out_im)), q[0].im);
      chk("out_idx", int'(out_idx), q[0].idx);
      chk("out_last", int'(out_last), int'(q[0].idx == 3));
    end else if (wb_rst_i) begin
      chk("rst_re", int'(out_re), 0);
      chk("rst_im", int'(out_im), 0);
      chk("rst_idx", int'(out_idx), 0);
      chk("rst_last", int'(out_last), 0);
    end
  end

  task automatic next_cycle();
    @(negedge wb_clk_i);
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_in(input int r0, input int i0, input int r1, input int i1,
                        input int r2, input int i2, input int r3, input int i3);
    xr_s[0] = W'(r0); xi_s[0] = W'(i0);
    xr_s[1] = W'(r1); xi_s[1] = W'(i1);
    xr_s[2] = W'(r2); xi_s[2] = W'(i2);
    xr_s[3] = W'(r3); xi_s[3] = W'(i3);
  endtask

  task automatic set_rand();
    for (int j = 0; j < 4; j++) begin
      xr_s[j] = W'($urandom);
      xi_s[j] = W'($urandom);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input bit iv, input bit sc);
    int t;
    in_valid = 1'b1;
    inv = iv;
    scale = sc;
    t = 0;
    forever begin
      #1;
      if (in_ready) break;
      if (t > 60) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      t++;
      next_cycle();
    end
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (out_valid && t < 100) begin
      next_cycle();
      t++;
    end
    if (out_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    wb_rst_i = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    inv = 1'b0;
    scale = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 wb_rst_i = 1'b1;

    chk("pin_fwd_x0r", bfly(1, 0, 2, 0, 3, 0, 4, 0, 0, 1'b0, 1'b0, 1'b0), 10);
    chk("pin_fwd_x1i", bfly(1, 0, 2, 0, 3, 0, 4, 0, 1, 1'b0, 1'b0, 1'b1), 2);
    chk("pin_fwd_x3i", bfly(1, 0, 2, 0, 3, 0, 4, 0, 3, 1'b0, 1'b0, 1'b1), -2);
    chk("pin_inv_x0r", bfly(1, 0, 2, 0, 3, 0, 4, 0, 0, 1'b1, 1'b1, 1'b0), 2);
    chk("pin_inv_x1i", bfly(1, 0, 2, 0, 3, 0, 4, 0, 1, 1'b1, 1'b1, 1'b1), -1);
    chk("pin_inv_x3i", bfly(1, 0, 2, 0, 3, 0, 4, 0, 3, 1'b1, 1'b1, 1'b1), 0);
    chk("pin_ext_x0r", bfly(-8, -8, -8, -8, -8, -8, -8, -8, 0, 1'b0, 1'b0, 1'b0), -32);
    chk("pin_ext_x2i", bfly(-8, -8, -8, -8, -8, -8, -8, -8, 2, 1'b0, 1'b0, 1'b1), 0);
    chk("pin_ext_x1r", bfly(7, 7, 7, -8, -8, -8, -8, 7, 1, 1'b1, 1'b0, 1'b0), 30);

    repeat (3) next_cycle();
    wb_rst_i = 1'b0;
    repeat (2) next_cycle();
    chk("idle_done_cnt", int'(done_cnt), 0);
    chk("idle_in_ready", int'(in_ready), 1);

    set_in(1, 0, 2, 0, 3, 0, 4, 0);
    send(1'b0, 1'b0);
    chk("basic_x0_re", int'($signed(out_re)), 10);
    drain();
    chk("basic_done_cnt", int'(done_cnt), 1);

    send(1'b1, 1'b1);
    chk("invsc_x0_re", int'($signed(out_re)), 2);
    drain();

    set_in(-8, -8, -8, -8, -8, -8, -8, -8);
    send(1'b0, 1'b0);
    chk("ext_x0_im", int'($signed(out_im)), -32);
    set_in(7, 7, 7, -8, -8, -8, -8, 7);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    drain();

    // Backpressure at idx 1, then a back-to-back transaction.
    set_rand();
    send(1'b0, 1'b1);
    next_cycle();
    out_ready = 1'b0;
    repeat (3) next_cycle();
    #1;
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_idx", int'(out_idx), 1);
    out_ready = 1'b1;
    set_rand();
    send(1'b1, 1'b0);
    chk("b2b_valid", int'(out_valid), 1);
    chk("b2b_idx", int'(out_idx), 0);
    drain();

    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      set_rand();
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) next_cycle();
    end
    drain();

    // Reset at idx 2 discards the partial butterfly.
    set_rand();
    send(1'b0, 1'b0);
    next_cycle();
    next_cycle();
    chk("mid_idx", int'(out_idx), 2);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    next_cycle();
    wb_rst_i = 1'b0;
    next_cycle();
    chk("mid_rst_done", int'(done_cnt), 0);

    for (int n = 0; n < (1 << CW); n++) begin
      set_rand();
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    chk("wrap_done_cnt", int'(done_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
